// File: rtl/rc4_stream_cipher.sv
// RC4 keystream consumer: buffers keystream bytes in a small FIFO and XORs them
// with host bytes one-for-one; the same path encrypts and decrypts.
module rc4_stream_cipher #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] msg_len,
    input  logic                 ks_valid,
    input  logic [7:0]           ks_data,
    output logic                 ks_ready,
    input  logic                 din_valid,
    input  logic [7:0]           din,
    output logic                 din_ready,
    output logic                 dout_valid,
    output logic [7:0]           dout,
    input  logic                 dout_ready,
    output logic                 busy,
    output logic                 done,
    output logic [LEN_WIDTH-1:0] byte_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] len, ks_cnt, in_cnt;
    logic [7:0]           mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 fifo_empty, fifo_full, push, pop, out_hs;

    // Extra pointer MSB tells a full FIFO from an empty one when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign ks_ready  = (state == RUN) && !fifo_full && (ks_cnt < len);
    assign din_ready = (state == RUN) && !fifo_empty && (in_cnt < len)
                       && (!dout_valid || dout_ready);
    assign push      = ks_valid && ks_ready;
    assign pop       = din_valid && din_ready;
    assign out_hs    = dout_valid && dout_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= ks_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            len        <= '0;
            ks_cnt     <= '0;
            in_cnt     <= '0;
            byte_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            dout_valid <= 1'b0;
            dout       <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
                ks_cnt <= ks_cnt + LEN_WIDTH'(1);
            end
            // A reload in the same cycle as the handshake keeps dout_valid high.
            if (pop) begin
                rd_ptr     <= rd_ptr + (AW+1)'(1);
                in_cnt     <= in_cnt + LEN_WIDTH'(1);
                dout       <= din ^ mem[rd_ptr[AW-1:0]];
                dout_valid <= 1'b1;
            end else if (out_hs) begin
                dout_valid <= 1'b0;
            end
            if (out_hs) byte_cnt <= byte_cnt + LEN_WIDTH'(1);

            case (state)
                IDLE: begin
                    if (start) begin
                        if (msg_len != '0) begin
                            len      <= msg_len;
                            ks_cnt   <= '0;
                            in_cnt   <= '0;
                            byte_cnt <= '0;
                            state    <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pop && (in_cnt + LEN_WIDTH'(1) == len)) state <= DRAIN;
                end
                DRAIN: begin
                    if (out_hs) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rc4_stream_cipher.sv
// Scoreboard bench for rc4_stream_cipher: expected bytes are queued at each din
// handshake and compared when the matching dout handshake is seen.
module tb_rc4_stream_cipher;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] msg_len;
    logic        ks_valid, ks_ready, din_valid, din_ready;
    logic [7:0]  ks_data, din, dout;
    logic        dout_valid, dout_ready, busy, done;
    logic [15:0] byte_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] ks_buf [64];
    logic [7:0] in_buf [64];
    logic [7:0] out_buf[64];
    logic [7:0] pt_buf [64];
    logic [7:0] exp_q  [$];
    int n_out, n_done;

    rc4_stream_cipher #(.FIFO_DEPTH(4), .LEN_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .msg_len(msg_len),
        .ks_valid(ks_valid), .ks_data(ks_data), .ks_ready(ks_ready),
        .din_valid(din_valid), .din(din), .din_ready(din_ready),
        .dout_valid(dout_valid), .dout(dout), .dout_ready(dout_ready),
        .busy(busy), .done(done), .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        start = 0; msg_len = 0; ks_valid = 0; ks_data = 0;
        din_valid = 0; din = 0; dout_ready = 0;
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < len; i++) begin
            ks_buf[i] = 8'($urandom_range(0, 255));
            in_buf[i] = 8'($urandom_range(0, 255));
        end
    endtask

    // Drives one message from start to done. Returns early after rst_after output bytes.
    task automatic run_msg(input int len, input int din_delay, input bit rand_rdy,
                           input int rst_after, input int restart_cyc);
        int ks_idx = 0;
        int din_idx = 0;
        int last_hs = -10;
        bit stalled = 0;
        bit ks_chk = 0;
        logic [7:0] held = 0;
        logic [7:0] exp_b;
        n_out = 0; n_done = 0; exp_q.delete();
        start = 1; msg_len = len[15:0];
        @(posedge clk); #1;
        start = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ks_valid   = (ks_idx < len);
            ks_data    = ks_buf[ks_idx];
            din_valid  = (cyc >= din_delay) && (din_idx < len);
            din        = in_buf[din_idx];
            dout_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            start      = (cyc == restart_cyc);
            msg_len    = (cyc == restart_cyc) ? 16'd2 : len[15:0];
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (dout_valid !== 1'b1 || dout !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b dout=%h, need valid=1 dout=%h", dout_valid, dout, held);
                end
            end
            stalled = dout_valid && !dout_ready;
            held    = dout;
            if (stalled) begin
                checks++;
                if (din_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL din_ready_stall: got %b, need 0", din_ready);
                end
            end
            if (ks_idx == len && !ks_chk) begin
                ks_chk = 1;
                checks++;
                if (ks_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ks_ready_after_last: got %b, need 0", ks_ready);
                end
            end
            if (din_delay >= 6 && cyc == din_delay - 1) begin
                checks++;
                if (ks_idx != 4 || ks_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL fifo_full: pushes=%0d ks_ready=%b, need pushes=4 ks_ready=0", ks_idx, ks_ready);
                end
            end
            if (done === 1'b1) begin
                checks++;
                n_done++;
                if (n_out != len || cyc != last_hs + 1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL done_timing: outs=%0d cyc=%0d last_hs=%0d busy=%b, need outs=%0d cyc=last_hs+1 busy=0",
                             n_out, cyc, last_hs, busy, len);
                end
                break;
            end
            if (dout_valid && dout_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL dout_extra: got %h with nothing expected", dout);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (dout !== exp_b) begin
                        errors++;
                        $display("FAIL dout_byte%0d: got %h, need %h", n_out, dout, exp_b);
                    end
                end
                out_buf[n_out] = dout;
                n_out++;
                last_hs = cyc;
                if (n_out == rst_after) return;
            end
            if (ks_valid && ks_ready) ks_idx++;
            if (din_valid && din_ready) begin
                exp_q.push_back(in_buf[din_idx] ^ ks_buf[din_idx]);
                din_idx++;
            end
            @(posedge clk); #1;
        end
        if (n_done == 0) begin
            checks++; errors++;
            $display("FAIL msg_timeout: got outs=%0d no done, need %0d outs and done", n_out, len);
        end
    endtask

    task automatic post_check(input int len);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || byte_cnt !== len[15:0]) begin
            errors++;
            $display("FAIL post_done: done=%b byte_cnt=%0d, need done=0 byte_cnt=%0d", done, byte_cnt, len);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checks++;
        if ({ks_ready, din_ready, dout_valid, busy, done} !== 5'b0 || dout !== 8'h00 || byte_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: ks_rdy=%b din_rdy=%b dv=%b busy=%b done=%b dout=%h cnt=%0d, need all 0",
                     ks_ready, din_ready, dout_valid, busy, done, dout, byte_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [7:0] want [4];
        want[0] = 8'h24; want[1] = 8'h85; want[2] = 8'h12; want[3] = 8'h29;
        ks_buf[0] = 8'h25; ks_buf[1] = 8'h87; ks_buf[2] = 8'h11; ks_buf[3] = 8'h2D;
        in_buf[0] = 8'h01; in_buf[1] = 8'h02; in_buf[2] = 8'h03; in_buf[3] = 8'h04;
        run_msg(4, 0, 0, -1, -1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_buf[i] !== want[i]) begin
                errors++;
                $display("FAIL basic_vec%0d: got %h, need %h", i, out_buf[i], want[i]);
            end
        end
        post_check(4);
    endtask

    task automatic test_fifo_full();
        fill_random(8);
        run_msg(8, 10, 0, -1, -1);
        post_check(8);
    endtask

    task automatic test_roundtrip();
        fill_random(12);
        for (int i = 0; i < 12; i++) pt_buf[i] = in_buf[i];
        run_msg(12, 0, 0, -1, -1);
        post_check(12);
        for (int i = 0; i < 12; i++) in_buf[i] = out_buf[i];
        run_msg(12, 0, 0, -1, -1);
        post_check(12);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (out_buf[i] !== pt_buf[i]) begin
                errors++;
                $display("FAIL roundtrip%0d: got %h, need %h", i, out_buf[i], pt_buf[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        fill_random(16);
        run_msg(16, 0, 1, -1, -1);
        post_check(16);
    endtask

    task automatic test_reset_mid();
        fill_random(8);
        run_msg(8, 0, 0, 3, -1);
        rst = 1; idle_inputs();
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        checks++;
        if (dout_valid !== 1'b0 || busy !== 1'b0 || ks_ready !== 1'b0 || din_ready !== 1'b0 || byte_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid: dv=%b busy=%b ks_rdy=%b din_rdy=%b cnt=%0d, need all 0",
                     dout_valid, busy, ks_ready, din_ready, byte_cnt);
        end
        @(posedge clk); #1;
        fill_random(2);
        run_msg(2, 0, 0, -1, -1);
        post_check(2);
    endtask

    task automatic test_zero_len();
        start = 1; msg_len = 16'd0;
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_done: done=%b busy=%b dv=%b, need done=1 busy=0 dv=0", done, busy, dout_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_after: done=%b busy=%b, need 0 0", done, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_during_run();
        fill_random(6);
        run_msg(6, 0, 0, -1, 3);
        post_check(6);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fifo_full();
        test_roundtrip();
        test_back_to_back();
        test_reset_mid();
        test_zero_len();
        test_start_during_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
